// File: rtl/relogio_ctrl.sv
// rtl/relogio_ctrl.sv - mode FSM, time-of-day and stopwatch counters for the clock/stopwatch
module relogio_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_start,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic       running,
    output logic [6:0] disp_hr,
    output logic [5:0] disp_min,
    output logic [5:0] disp_sec,
    output logic [6:0] disp_cs
);

    typedef enum logic [1:0] {
        ST_CLOCK     = 2'b00,
        ST_SET_HR    = 2'b01,
        ST_SET_MIN   = 2'b10,
        ST_STOPWATCH = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic       running_q, running_d;

    logic [4:0] tod_hr_q, tod_hr_d;
    logic [5:0] tod_min_q, tod_min_d;
    logic [5:0] tod_sec_q, tod_sec_d;
    logic [6:0] tod_cs_q, tod_cs_d;

    logic [6:0] sw_hr_q, sw_hr_d;
    logic [5:0] sw_min_q, sw_min_d;
    logic [5:0] sw_sec_q, sw_sec_d;
    logic [6:0] sw_cs_q, sw_cs_d;

    logic do_mode, do_sel, do_start, do_inc;
    logic set_exit;
    logic tod_en;
    logic sw_en;

    // Only the highest-priority button pulse in a cycle is acted on.
    always_comb begin
        do_mode  = btn_mode;
        do_sel   = btn_sel & ~btn_mode;
        do_start = btn_start & ~btn_mode & ~btn_sel;
        do_inc   = btn_inc & ~btn_mode & ~btn_sel & ~btn_start;
    end

    // Next mode and run flag; leaving a set state is flagged so sec/cs restart from zero.
    always_comb begin
        state_d   = state_q;
        running_d = running_q;
        case (state_q)
            ST_CLOCK: begin
                if (do_mode)     state_d = ST_STOPWATCH;
                else if (do_sel) state_d = ST_SET_HR;
            end
            ST_SET_HR: begin
                if (do_mode)     state_d = ST_CLOCK;
                else if (do_sel) state_d = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (do_mode || do_sel) state_d = ST_CLOCK;
            end
            ST_STOPWATCH: begin
                if (do_mode)       state_d = ST_CLOCK;
                else if (do_start) running_d = ~running_q;
            end
            default: state_d = ST_CLOCK;
        endcase
        set_exit = ((state_q == ST_SET_HR) || (state_q == ST_SET_MIN)) && (state_d != state_q);
    end

    // Time-of-day: ticks only outside the set states; set-field increments and exit clearing.
    always_comb begin
        tod_hr_d  = tod_hr_q;
        tod_min_d = tod_min_q;
        tod_sec_d = tod_sec_q;
        tod_cs_d  = tod_cs_q;
        tod_en    = tick && ((state_q == ST_CLOCK) || (state_q == ST_STOPWATCH));
        if (tod_en) begin
            if (tod_cs_q == 7'd99) begin
                tod_cs_d = 7'd0;
                if (tod_sec_q == 6'd59) begin
                    tod_sec_d = 6'd0;
                    if (tod_min_q == 6'd59) begin
                        tod_min_d = 6'd0;
                        tod_hr_d  = (tod_hr_q == 5'd23) ? 5'd0 : tod_hr_q + 5'd1;
                    end else begin
                        tod_min_d = tod_min_q + 6'd1;
                    end
                end else begin
                    tod_sec_d = tod_sec_q + 6'd1;
                end
            end else begin
                tod_cs_d = tod_cs_q + 7'd1;
            end
        end
        if ((state_q == ST_SET_HR) && do_inc)
            tod_hr_d = (tod_hr_q == 5'd23) ? 5'd0 : tod_hr_q + 5'd1;
        if ((state_q == ST_SET_MIN) && do_inc)
            tod_min_d = (tod_min_q == 6'd59) ? 6'd0 : tod_min_q + 6'd1;
        if (set_exit) begin
            tod_sec_d = 6'd0;
            tod_cs_d  = 7'd0;
        end
    end

    // Stopwatch: counts whenever running in any mode; clear only when stopped in stopwatch view.
    always_comb begin
        sw_hr_d  = sw_hr_q;
        sw_min_d = sw_min_q;
        sw_sec_d = sw_sec_q;
        sw_cs_d  = sw_cs_q;
        sw_en    = tick && running_q;
        if (sw_en) begin
            if (sw_cs_q == 7'd99) begin
                sw_cs_d = 7'd0;
                if (sw_sec_q == 6'd59) begin
                    sw_sec_d = 6'd0;
                    if (sw_min_q == 6'd59) begin
                        sw_min_d = 6'd0;
                        sw_hr_d  = (sw_hr_q == 7'd99) ? 7'd0 : sw_hr_q + 7'd1;
                    end else begin
                        sw_min_d = sw_min_q + 6'd1;
                    end
                end else begin
                    sw_sec_d = sw_sec_q + 6'd1;
                end
            end else begin
                sw_cs_d = sw_cs_q + 7'd1;
            end
        end
        if ((state_q == ST_STOPWATCH) && do_sel && !running_q) begin
            sw_hr_d  = 7'd0;
            sw_min_d = 6'd0;
            sw_sec_d = 6'd0;
            sw_cs_d  = 7'd0;
        end
    end

    // State register for the FSM and both counters; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLOCK;
            running_q <= 1'b0;
            tod_hr_q  <= 5'd0;
            tod_min_q <= 6'd0;
            tod_sec_q <= 6'd0;
            tod_cs_q  <= 7'd0;
            sw_hr_q   <= 7'd0;
            sw_min_q  <= 6'd0;
            sw_sec_q  <= 6'd0;
            sw_cs_q   <= 7'd0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            tod_hr_q  <= tod_hr_d;
            tod_min_q <= tod_min_d;
            tod_sec_q <= tod_sec_d;
            tod_cs_q  <= tod_cs_d;
            sw_hr_q   <= sw_hr_d;
            sw_min_q  <= sw_min_d;
            sw_sec_q  <= sw_sec_d;
            sw_cs_q   <= sw_cs_d;
        end
    end

    // Display shows the stopwatch in stopwatch mode, time-of-day otherwise.
    always_comb begin
        mode    = state_q;
        running = running_q;
        if (state_q == ST_STOPWATCH) begin
            disp_hr  = sw_hr_q;
            disp_min = sw_min_q;
            disp_sec = sw_sec_q;
            disp_cs  = sw_cs_q;
        end else begin
            disp_hr  = {2'b00, tod_hr_q};
            disp_min = tod_min_q;
            disp_sec = tod_sec_q;
            disp_cs  = tod_cs_q;
        end
    end

endmodule
